signed_shft_div: RTL

SIGNED_SHFT_DIV -- requirements
Module: signed_shft_div

---
 rtl/div_pkg.sv | 18 +
 rtl/div_twos_neg.sv | 24 ++
 rtl/signed_shft_div.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the signed shift-subtract divider:
//   DIV_W       - default two's-complement operand/result width
//   div_state_t - sequencer state type and its encodings
// ---------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_twos_neg.sv
// ---------------------------------------------------------------------------
// div_twos_neg
// Combinational conditional two's-complement negation of an N-bit vector.
// Used both to take operand magnitudes and to re-apply result signs.
// Ports:
//   val - input vector
//   neg - when high, res = -val (mod 2^N); otherwise res = val
//   res - result
// ---------------------------------------------------------------------------
module div_twos_neg
  import div_pkg::*;
#(
  parameter int N = DIV_W
) (
  input  logic [N-1:0] val,
  input  logic         neg,
  output logic [N-1:0] res
);

  // -(-2^(N-1)) wraps back to 2^(N-1), which read as unsigned is the correct
  // magnitude of the most negative operand.
  assign res = neg ? (~val + 1'b1) : val;

endmodule

// File: rtl/signed_shft_div.sv
// ---------------------------------------------------------------------------
// signed_shft_div
// Multi-cycle signed divider: sign/magnitude split, N restoring
// shift-subtract steps, then sign fix-up. Quotient truncates toward zero and
// the remainder takes the sign of the dividend. -2^(N-1) / -1 wraps to
// -2^(N-1) with remainder 0.
//
// Optional feature (macro SIGNED_DIV_ZERO_DETECT_EN):
//   defined   - divisor == 0 skips CALC/FIX; done one cycle after start with
//               err = 1, quo = all ones, rem = dividend.
//   undefined - err is tied low; divide-by-zero runs the normal sequence and
//               returns the raw algorithm result.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset, clears all state and outputs
//   start    - request pulse, accepted only in IDLE while done is low
//   dividend - signed numerator, sampled on the accepted start
//   divisor  - signed denominator, sampled on the accepted start
//   quo, rem - registered signed quotient / remainder, held until next done
//   busy     - high from the cycle after an accepted start until done
//   done     - single-cycle pulse marking quo/rem/err valid
//   err      - divide-by-zero flag, valid with done
// Latency: done asserts N+2 cycles after the accepted start edge.
// ---------------------------------------------------------------------------
module signed_shft_div
  import div_pkg::*;
#(
  parameter int N = DIV_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [N-1:0] dividend,
  input  logic signed [N-1:0] divisor,
  output logic signed [N-1:0] quo,
  output logic signed [N-1:0] rem,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int            CW   = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  div_state_t     state;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   q_reg;     // dividend magnitude shifting out, quotient in
  logic [N:0]     r_reg;     // partial remainder
  logic [N-1:0]   b_mag;
  logic           q_neg;     // operand signs differ
  logic           r_neg;     // dividend negative

  logic [N-1:0]   a_mag_in;
  logic [N-1:0]   b_mag_in;
  logic [N-1:0]   q_fix;
  logic [N-1:0]   r_fix;
  logic [N+1:0]   trial;

`ifdef SIGNED_DIV_ZERO_DETECT_EN
  logic           err_flag;
`endif

  div_twos_neg #(.N(N)) u_neg_a (
    .val (dividend),
    .neg (dividend[N-1]),
    .res (a_mag_in)
  );

  div_twos_neg #(.N(N)) u_neg_b (
    .val (divisor),
    .neg (divisor[N-1]),
    .res (b_mag_in)
  );

  div_twos_neg #(.N(N)) u_neg_q (
    .val (q_reg),
    .neg (q_neg),
    .res (q_fix)
  );

  // After the last step the remainder is below |divisor| <= 2^(N-1) (or equal
  // to |dividend| for a zero divisor), so its low N bits hold it exactly.
  div_twos_neg #(.N(N)) u_neg_r (
    .val (r_reg[N-1:0]),
    .neg (r_neg),
    .res (r_fix)
  );

  // Shift the next dividend bit into the partial remainder and try to
  // subtract; the extra top bit is the borrow that decides restore vs keep.
  assign trial = {r_reg, q_reg[N-1]} - {2'b00, b_mag};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      q_reg <= '0;
      r_reg <= '0;
      b_mag <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      quo   <= '0;
      rem   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SIGNED_DIV_ZERO_DETECT_EN
      err_flag <= 1'b0;
      err      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        // Operand capture; a start landing on the done cycle is dropped.
        IDLE: begin
          if (start && !done) begin
            busy  <= 1'b1;
            q_neg <= dividend[N-1] ^ divisor[N-1];
            r_neg <= dividend[N-1];
            q_reg <= a_mag_in;
            r_reg <= '0;
            b_mag <= b_mag_in;
            cnt   <= '0;
            state <= CALC;
`ifdef SIGNED_DIV_ZERO_DETECT_EN
            err_flag <= 1'b0;
            if (divisor == '0) begin
              q_reg    <= '1;
              r_reg    <= {1'b0, dividend};
              err_flag <= 1'b1;
              state    <= DONE;
            end
`endif
          end
        end

        // One restoring step per cycle, quotient bits enter MSB-first.
        CALC: begin
          if (!trial[N+1]) begin
            r_reg <= trial[N:0];
            q_reg <= {q_reg[N-2:0], 1'b1};
          end else begin
            r_reg <= {r_reg[N-1:0], q_reg[N-1]};
            q_reg <= {q_reg[N-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= FIX;
          end
        end

        // Sign fix-up of the unsigned magnitudes.
        FIX: begin
          q_reg <= q_fix;
          r_reg <= {1'b0, r_fix};
          state <= DONE;
        end

        // Publish results.
        DONE: begin
          quo   <= q_reg;
          rem   <= r_reg[N-1:0];
`ifdef SIGNED_DIV_ZERO_DETECT_EN
          err   <= err_flag;
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifndef SIGNED_DIV_ZERO_DETECT_EN
  assign err = 1'b0;
`endif

endmodule
